// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame sequencer (header/hi/lo), optional RX_CHECKSUM_EN checksum byte
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter logic [15:0] TIMEOUT    = 16'd50000,
  parameter logic [15:0] ERR_CODE_P = 16'hEEE1,
  parameter logic [15:0] ERR_CODE_F = 16'hEEE2,
  parameter logic [15:0] ERR_CODE_T = 16'hEEE3,
  parameter logic [15:0] ERR_CODE_C = 16'hEEEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_perror,
  input  logic        rx_ferror,
  output logic [15:0] word_out,
  output logic        word_strobe,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GET_HI = 2'd1,
`ifdef RX_CHECKSUM_EN
    S_GET_LO = 2'd2,
    S_GET_CHK = 2'd3
`else
    S_GET_LO = 2'd2
`endif
  } state_e;

  // Timer value on the last silent cycle still allowed before the frame is dropped
  localparam logic [15:0] TIMER_LAST = TIMEOUT - 16'd1;

  state_e      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
`ifdef RX_CHECKSUM_EN
  logic [7:0]  lo_q, lo_d;
`endif
  logic [15:0] timer_q, timer_d;
  logic [15:0] word_q, word_d;
  logic        strobe_q, strobe_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        err_ev;
  logic        byte_ev;
  logic        in_frame;
  logic        timeout_ev;
  logic [15:0] err_code;
  logic        abort;
  logic [15:0] abort_code;
  logic        commit;
  logic [15:0] commit_word;

  // Decode this cycle's events; errors outrank bytes, bytes outrank the timeout
  always_comb begin
    err_ev     = rx_perror | rx_ferror;
    byte_ev    = rx_valid & ~err_ev;
    in_frame   = (state_q != S_IDLE);
    timeout_ev = in_frame & ~err_ev & ~byte_ev & (timer_q == TIMER_LAST);
    err_code   = rx_ferror ? ERR_CODE_F : ERR_CODE_P;
  end

  // Next-state, timer and commit decisions
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
`ifdef RX_CHECKSUM_EN
    lo_d        = lo_q;
`endif
    timer_d     = timer_q;
    word_d      = word_q;
    strobe_d    = 1'b0;
    ferr_d      = ferr_q;
    cnt_d       = cnt_q;
    abort       = 1'b0;
    abort_code  = ERR_CODE_P;
    commit      = 1'b0;
    commit_word = 16'h0000;

    if (!in_frame) begin
      // Stray bytes and error flags outside a frame are ignored
      timer_d = 16'h0000;
      if (byte_ev && (rx_data == HEADER)) begin
        state_d = S_GET_HI;
      end
    end else if (err_ev) begin
      abort      = 1'b1;
      abort_code = err_code;
    end else if (byte_ev) begin
      timer_d = 16'h0000;
      case (state_q)
        S_GET_HI: begin
          hi_d    = rx_data;
          state_d = S_GET_LO;
        end
`ifdef RX_CHECKSUM_EN
        S_GET_LO: begin
          lo_d    = rx_data;
          state_d = S_GET_CHK;
        end
        S_GET_CHK: begin
          if (rx_data == (HEADER ^ hi_q ^ lo_q)) begin
            commit      = 1'b1;
            commit_word = {hi_q, lo_q};
          end else begin
            abort      = 1'b1;
            abort_code = ERR_CODE_C;
          end
        end
`else
        S_GET_LO: begin
          commit      = 1'b1;
          commit_word = {hi_q, rx_data};
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end else if (timeout_ev) begin
      abort      = 1'b1;
      abort_code = ERR_CODE_T;
    end else begin
      timer_d = timer_q + 16'd1;
    end

    if (commit) begin
      word_d   = commit_word;
      strobe_d = 1'b1;
      ferr_d   = 1'b0;
      state_d  = S_IDLE;
      timer_d  = 16'h0000;
    end

    if (abort) begin
      word_d   = abort_code;
      strobe_d = 1'b1;
      ferr_d   = 1'b1;
      cnt_d    = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
      state_d  = S_IDLE;
      timer_d  = 16'h0000;
    end
  end

  // State and output registers, cleared immediately by reset even mid-frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      hi_q     <= 8'h00;
`ifdef RX_CHECKSUM_EN
      lo_q     <= 8'h00;
`endif
      timer_q  <= 16'h0000;
      word_q   <= 16'h0000;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
      cnt_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
`ifdef RX_CHECKSUM_EN
      lo_q     <= lo_d;
`endif
      timer_q  <= timer_d;
      word_q   <= word_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign word_out    = word_q;
  assign word_strobe = strobe_q;
  assign frame_err   = ferr_q;
  assign err_cnt     = cnt_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Receive-side sequencer between the UART receiver and the display register path.
- Consumes byte strobes and parity/framing error flags, and recognises frames of the form header byte, high byte, low byte.
- Commits a 16-bit display word, or a 16-bit error code, with a one-cycle strobe.
- Handles inter-byte timeout and counts aborted frames.

Parameters:
- HEADER, 8'hA5, frame start byte.
- TIMEOUT, 16'd50000, idle clocks allowed between bytes inside a frame; legal range 2..65535.
- ERR_CODE_P, 16'hEEE1, word committed on parity error.
- ERR_CODE_F, 16'hEEE2, word committed on framing error.
- ERR_CODE_T, 16'hEEE3, word committed on timeout.
- ERR_CODE_C, 16'hEEEC, word committed on checksum mismatch (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte, valid when rx_valid=1.
- rx_valid  in  1  one-cycle byte strobe from the receiver.
- rx_perror  in  1  parity error flag; may be high with rx_valid low.
- rx_ferror  in  1  framing error flag; may be high with rx_valid low.
- word_out  out  16  last committed word or error code.
- word_strobe  out  1  one-cycle pulse when word_out is updated.
- frame_err  out  1  sticky; set on an aborted frame, cleared on the next good frame.
- err_cnt  out  8  saturating count of aborted frames.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0), asynchronous and effective immediately, including mid-frame:
  - state=IDLE
  - word_out=16'h0000, word_strobe=0, frame_err=0, err_cnt=0, busy=0
  - hi_reg=0, timer=0
- Events, evaluated every clock:
  - err_ev = rx_perror | rx_ferror, regardless of rx_valid.
  - byte_ev = rx_valid & ~err_ev.
  - Priority: err_ev > byte_ev > timeout.
  - Error code selection: ERR_CODE_F if rx_ferror=1, else ERR_CODE_P.
- States:
  - IDLE: byte_ev with rx_data==HEADER -> GET_HI, timer=0. Any other byte_ev is ignored. err_ev is ignored (no frame in progress).
  - GET_HI: byte_ev -> hi_reg=rx_data, timer=0, go to GET_LO.
  - GET_LO: byte_ev -> commit {hi_reg, rx_data}, frame_err=0, go to IDLE.
  - HEADER-valued bytes inside a frame are treated as data; there is no resync.
- Abort, in GET_HI or GET_LO (and GET_CHK when enabled), on err_ev or timeout:
  - Commit the error code, frame_err=1, err_cnt+1 saturating at 8'hFF, go to IDLE.
- Timer (16 bits):
  - Increments each clock in non-IDLE states without byte_ev.
  - Timeout fires when timer==TIMEOUT-1 and there is neither err_ev nor byte_ev in that cycle, i.e. on the TIMEOUT-th silent cycle.
  - A byte arriving on that same cycle is accepted; there is no timeout.
- Commit: all outputs are registered.
  - word_out and word_strobe=1 appear the clock after the sampling edge of the final byte or the error.
  - word_strobe is high for exactly one cycle.
  - Back-to-back frames need no gap: a header may arrive the cycle after the commit.
- busy reflects the registered state (0 only in IDLE).

Optional Feature:
- Macro: RX_CHECKSUM_EN.
- Defined:
  - A GET_CHK state follows GET_LO; the low byte is held in lo_reg.
  - Byte equal to HEADER^hi^lo -> commit {hi,lo} as a good frame.
  - Mismatch -> commit ERR_CODE_C as an abort (frame_err=1, err_cnt+1).
  - Timeout and error rules in GET_CHK are the same as in other frame states.
- Undefined: no GET_CHK state; the frame commits on the low byte; ERR_CODE_C is unused.

Test Plan:
- Good frame: release reset; strobe bytes A5, 12, 34 at 10-cycle spacing -> one cycle after the 34 strobe, word_out=16'h1234 and word_strobe high for 1 cycle; busy=0 afterwards; err_cnt=0.
- Idle noise: in IDLE, send byte 4D, then pulse rx_perror for one cycle -> no strobe, word_out unchanged, err_cnt=0, busy=0.
- Mid-frame parity error: A5, 12, then rx_perror=1 with rx_valid=0 -> word_out=16'hEEE1, frame_err=1, err_cnt=1. Then A5, FF, 00 -> word_out=16'hFF00, frame_err=0, err_cnt=1.
- Error priority: in GET_HI, assert rx_perror=1, rx_ferror=1 and rx_valid=1 in the same cycle -> word_out=16'hEEE2, byte discarded, state IDLE.
- Timeout with TIMEOUT=20:
  - A5 then silence -> 16'hEEE3 strobed after the 20th silent cycle.
  - Repeat with the high byte landing on exactly the 20th silent cycle -> accepted, no error.
  - Also: 255 aborts followed by 1 more abort -> err_cnt stays at FF.
- Reset mid-frame: A5, 12, then reset=0 between edges -> all outputs 0 immediately. Release; A5, AB, CD -> 16'hABCD. With RX_CHECKSUM_EN: A5, 12, 34, 83 -> 16'h1234; A5, 12, 34, 84 -> 16'hEEEC.
